// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse generator: FSM state encoding.
package pulse_gen_pkg;

    // Sequence phases; IDLE is the only non-busy state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_gen_cnt.sv
// Loadable down-counter shared by all phases of the pulse sequence.
// A phase of N cycles is loaded with N-1; the phase ends on the edge
// where the counter already reads zero.
module pulse_gen_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Pulse generator: turns a single-cycle trigger into a delayed output pulse
// of programmed width followed by a holdoff dead time. All outputs registered.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int RETRIG = 0,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              trig,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  holdoff,
    input  logic              clr_miss,
    output logic              y,
    output logic              busy,
    output logic              done,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
    localparam bit                RETRIG_EN = (RETRIG != 0);

    state_e           state, state_nx;
    logic [CNT_W-1:0] w_l, h_l;      // width (clamped) and holdoff latched at accept
    logic [CNT_W-1:0] w_eff;
    logic             cnt_ld, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             start;         // trig accepted (fresh or restart) this edge
    logic             miss;
    logic             done_nx, y_nx, busy_nx;

    // width of 0 behaves as a 1-cycle pulse
    assign w_eff = (width == '0) ? ONE : width;

    pulse_gen_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_ld),
        .load_val (cnt_val),
        .dec      (!cnt_ld),
        .zero     (cnt_zero)
    );

    // State and registered outputs; reset drops y immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            y     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            y     <= y_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next state, counter reload, accept/reject decisions.
    // The delay input goes straight into the counter on accept, so only width
    // and holdoff need their own latches. The last ACTIVE edge with no holdoff
    // and the last HOLDOFF edge both behave like IDLE so back-to-back triggers
    // on those edges are accepted.
    always_comb begin
        state_nx = state;
        cnt_ld   = 1'b0;
        cnt_val  = '0;
        start    = 1'b0;
        miss     = 1'b0;
        done_nx  = 1'b0;
        if (!en) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: start = trig;
                ST_DELAY: begin
                    if (trig && RETRIG_EN) begin
                        start = 1'b1;
                    end else begin
                        miss = trig;
                        if (cnt_zero) begin
                            state_nx = ST_ACTIVE;
                            cnt_ld   = 1'b1;
                            cnt_val  = w_l - ONE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_zero && (h_l == '0)) begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                        start    = trig;
                    end else if (trig && RETRIG_EN) begin
                        start = 1'b1;
                    end else begin
                        miss = trig;
                        if (cnt_zero) begin
                            done_nx  = 1'b1;
                            state_nx = ST_HOLDOFF;
                            cnt_ld   = 1'b1;
                            cnt_val  = h_l - ONE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_zero) begin
                        state_nx = ST_IDLE;
                        start    = trig;
                    end else begin
                        miss = trig;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
            if (start) begin
                cnt_ld = 1'b1;
                if (delay != '0) begin
                    state_nx = ST_DELAY;
                    cnt_val  = delay - ONE;
                end else begin
                    state_nx = ST_ACTIVE;
                    cnt_val  = w_eff - ONE;
                end
            end
        end
    end

    // Output levels follow the state being entered.
    always_comb begin
        y_nx    = (state_nx == ST_ACTIVE);
        busy_nx = (state_nx != ST_IDLE);
    end

    // Capture sequence parameters on every accept, including restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_l <= '0;
            h_l <= '0;
        end else if (start) begin
            w_l <= w_eff;
            h_l <= holdoff;
        end
    end

    // Saturating rejected-trigger count; clear beats a same-edge reject.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (clr_miss) begin
            miss_cnt <= '0;
        end else if (miss && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + MISS_ONE;
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: one RETRIG=0 and one RETRIG=1 instance share
// stimulus. Edge numbers in tags are relative to each test's first trigger.
module tb_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] delay = '0;
    logic [15:0] width = '0;
    logic [15:0] holdoff = '0;
    logic        clr_miss = 1'b0;
    logic        y0, busy0, done0, y1, busy1, done1;
    logic [7:0]  miss0, miss1;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pulse_gen #(.CNT_W(16), .RETRIG(0), .MISS_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .delay(delay),
        .width(width), .holdoff(holdoff), .clr_miss(clr_miss),
        .y(y0), .busy(busy0), .done(done0), .miss_cnt(miss0));

    pulse_gen #(.CNT_W(16), .RETRIG(1), .MISS_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .delay(delay),
        .width(width), .holdoff(holdoff), .clr_miss(clr_miss),
        .y(y1), .busy(busy1), .done(done1), .miss_cnt(miss1));

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Abort both instances and clear their miss counters.
    task automatic quiesce();
        en = 1'b0; trig = 1'b0; clr_miss = 1'b1;
        tick();
        en = 1'b1; clr_miss = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst y", y0, 0);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst miss", miss0, 0);
        rst_n = 1'b1;
        tick();
        quiesce();

        // 1: delay 3, width 4, holdoff 2
        delay = 3; width = 4; holdoff = 2;
        for (int e = 0; e <= 9; e++) begin
            trig = (e == 0);
            tick();
            chk($sformatf("t1 y e%0d", e), y0, int'(e >= 3 && e <= 6));
            chk($sformatf("t1 busy e%0d", e), busy0, int'(e <= 8));
            chk($sformatf("t1 done e%0d", e), done0, int'(e == 7));
        end
        // 1b: trig inside holdoff rejected, on its last edge accepted
        quiesce();
        for (int e = 0; e <= 12; e++) begin
            trig = (e == 0 || e == 8 || e == 9);
            tick();
            if (e == 8) chk("t1b miss holdoff", miss0, 1);
            if (e == 9) chk("t1b busy reaccept", busy0, 1);
            if (e == 11) chk("t1b y before", y0, 0);
            if (e == 12) chk("t1b y rise", y0, 1);
        end

        // 2: all zero, back-to-back on the fall edge
        quiesce();
        delay = 0; width = 0; holdoff = 0;
        for (int e = 0; e <= 3; e++) begin
            trig = (e <= 1);
            tick();
            chk($sformatf("t2 y e%0d", e), y0, int'(e <= 1));
            chk($sformatf("t2 done e%0d", e), done0, int'(e == 1 || e == 2));
            chk($sformatf("t2 busy e%0d", e), busy0, int'(e <= 1));
        end
        chk("t2 miss", miss0, 0);

        // 3: RETRIG=0 ignores trig during pulse; holdoff reject; clear wins
        quiesce();
        delay = 0; width = 10; holdoff = 3;
        for (int e = 0; e <= 13; e++) begin
            trig = (e == 0 || e == 4 || e == 11 || e == 12);
            clr_miss = (e == 12);
            tick();
            chk($sformatf("t3 y e%0d", e), y0, int'(e <= 9));
            chk($sformatf("t3 done e%0d", e), done0, int'(e == 10));
            if (e == 4) chk("t3 miss busy", miss0, 1);
            if (e == 11) chk("t3 miss holdoff", miss0, 2);
            if (e == 12) chk("t3 clr wins", miss0, 0);
        end
        clr_miss = 1'b0;
        chk("t3 idle", busy0, 0);

        // 4: RETRIG=1 restart during ACTIVE
        quiesce();
        delay = 2; width = 5; holdoff = 0;
        for (int e = 0; e <= 11; e++) begin
            trig = (e == 0 || e == 3);
            tick();
            chk($sformatf("t4 y e%0d", e), y1, int'(e == 2 || (e >= 5 && e <= 9)));
            chk($sformatf("t4 done e%0d", e), done1, int'(e == 10));
        end
        chk("t4 miss rt", miss1, 0);
        chk("t4 miss nort", miss0, 1);

        // 5: en abort mid-pulse; trig while disabled not counted
        quiesce();
        delay = 0; width = 8; holdoff = 0;
        for (int e = 0; e <= 5; e++) begin
            en = (e < 3);
            trig = (e == 0 || e == 4);
            tick();
            chk($sformatf("t5 y e%0d", e), y0, int'(e <= 2));
            chk($sformatf("t5 busy e%0d", e), busy0, int'(e <= 2));
            chk($sformatf("t5 done e%0d", e), done0, 0);
        end
        chk("t5 miss en0", miss0, 0);
        // 5b: saturation, 300 rejects
        en = 1'b1; width = 400;
        for (int e = 0; e <= 300; e++) begin
            trig = 1'b1;
            tick();
            if (e == 254) chk("t5 miss 254", miss0, 254);
        end
        trig = 1'b0;
        chk("t5 miss sat", miss0, 255);
        chk("t5 y still", y0, 1);

        // 6: async reset mid-ACTIVE, then a fresh pulse
        quiesce();
        delay = 1; width = 6; holdoff = 1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        chk("t6 y pre", y0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst y", y0, 0);
        chk("t6 rst busy", busy0, 0);
        chk("t6 rst done", done0, 0);
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        delay = 2; width = 2; holdoff = 0;
        for (int e = 0; e <= 4; e++) begin
            trig = (e == 0);
            tick();
            chk($sformatf("t6 y e%0d", e), y0, int'(e == 2 || e == 3));
            chk($sformatf("t6 busy e%0d", e), busy0, int'(e <= 3));
            chk($sformatf("t6 done e%0d", e), done0, int'(e == 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
